// File: rtl/sched_pkg.sv
// sched_pkg -- shared types and default sizing for the timestep scheduler.
//   state_t       : FSM state encoding used by timestep_scheduler
//   *_DEF         : default parameter values for the top level
package sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SNAP = 3'd1,
    HID  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int N_HIDDEN_DEF = 8;
  localparam int N_OUT_DEF    = 2;
  localparam int DIV_W_DEF    = 8;
  localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- single-bit two-flop synchronizer into the clk domain.
//   clk     : destination clock
//   reset_n : synchronous active-low reset, clears both flops
//   d       : asynchronous level input
//   q       : synchronized level, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/timestep_scheduler.sv
// timestep_scheduler -- sequences one network timestep in the clk domain.
//   clk, reset_n            : system clock, synchronous active-low reset
//   div_value               : SPI-loaded divider, captured on cdr_s rising
//   clk_div_ready_async     : SCLK-domain flag, divider configuration valid
//   input_spike_ready_async : SCLK-domain flag, input spikes valid
//   tick                    : one-cycle timestep pulse, period div_reg+1
//   snapshot_en             : one-cycle shadow-register capture pulse
//   update_en/layer_sel/neuron_sel : neuron update strobe and address
//   step_done               : one-cycle pulse at end of step
//   busy                    : step in progress
//   overrun                 : sticky, tick arrived while busy
//   step_count              : completed steps, wraps
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | waiting for tick with input spikes ready
// SNAP  | snapshot_en pulse, datapath captures shadow registers
// HID   | update hidden neurons 0..N_HIDDEN-1, one per cycle
// OUT   | update output neurons 0..N_OUT-1, one per cycle
// DONE  | step_done pulse, step_count incremented
module timestep_scheduler
  import sched_pkg::*;
#(
  parameter int N_HIDDEN = N_HIDDEN_DEF,
  parameter int N_OUT    = N_OUT_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div_value,
  input  logic             clk_div_ready_async,
  input  logic             input_spike_ready_async,
  output logic             tick,
  output logic             snapshot_en,
  output logic             update_en,
  output logic             layer_sel,
  output logic [3:0]       neuron_sel,
  output logic             step_done,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [3:0] HID_LAST = 4'(N_HIDDEN - 1);
  localparam logic [3:0] OUT_LAST = 4'(N_OUT - 1);

  logic             cdr_s;
  logic             isr_s;
  logic             cdr_q;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_cnt;
  state_t           state;

  sync_2ff u_sync_cdr (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (clk_div_ready_async),
    .q       (cdr_s)
  );

  sync_2ff u_sync_isr (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (input_spike_ready_async),
    .q       (isr_s)
  );

  // cdr_q doubles as the rising-edge detector and the counting enable: the
  // count only runs once div_reg holds the value captured on the edge, so a
  // stale div_reg can never produce a tick in the edge cycle itself.
  assign tick = cdr_s && cdr_q && (div_cnt == div_reg);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cdr_q   <= 1'b0;
      div_reg <= '0;
      div_cnt <= '0;
    end else begin
      cdr_q <= cdr_s;
      if (cdr_s && !cdr_q) begin
        div_reg <= div_value;
      end
      if (!cdr_s || !cdr_q || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      snapshot_en <= 1'b0;
      update_en   <= 1'b0;
      layer_sel   <= 1'b0;
      neuron_sel  <= 4'd0;
      step_done   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      step_count  <= '0;
    end else begin
      snapshot_en <= 1'b0;
      step_done   <= 1'b0;

      // A tick during a step is dropped; remember it until reset.
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick && isr_s) begin
            state       <= SNAP;
            snapshot_en <= 1'b1;
            busy        <= 1'b1;
          end
        end
        SNAP: begin
          state      <= HID;
          update_en  <= 1'b1;
          layer_sel  <= 1'b0;
          neuron_sel <= 4'd0;
        end
        HID: begin
          if (neuron_sel == HID_LAST) begin
            state      <= OUT;
            layer_sel  <= 1'b1;
            neuron_sel <= 4'd0;
          end else begin
            neuron_sel <= neuron_sel + 4'd1;
          end
        end
        OUT: begin
          if (neuron_sel == OUT_LAST) begin
            state      <= DONE;
            update_en  <= 1'b0;
            layer_sel  <= 1'b0;
            neuron_sel <= 4'd0;
            step_done  <= 1'b1;
            step_count <= step_count + CNT_W'(1);
          end else begin
            neuron_sel <= neuron_sel + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          update_en  <= 1'b0;
          layer_sel  <= 1'b0;
          neuron_sel <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timestep_scheduler.sv
// tb_timestep_scheduler -- self-checking bench for timestep_scheduler.
// The reference model predicts tick times arithmetically from the async edge
// cycles and derives all step outputs from the offset since the last step start.
module tb_timestep_scheduler;

  localparam int NH       = 8;
  localparam int NO       = 2;
  localparam int DIV_W    = 8;
  localparam int CNT_W    = 16;
  localparam int DONE_OFF = NH + NO + 2;
  localparam int BIG      = 1 << 28;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             cdr_a = 1'b0;
  logic             isr_a = 1'b0;
  logic             tick, snapshot_en, update_en, layer_sel, step_done, busy, overrun;
  logic [3:0]       neuron_sel;
  logic [CNT_W-1:0] step_count;

  timestep_scheduler #(.N_HIDDEN(NH), .N_OUT(NO), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .div_value               (div_value),
    .clk_div_ready_async     (cdr_a),
    .input_spike_ready_async (isr_a),
    .tick                    (tick),
    .snapshot_en             (snapshot_en),
    .update_en               (update_en),
    .layer_sel               (layer_sel),
    .neuron_sel              (neuron_sel),
    .step_done               (step_done),
    .busy                    (busy),
    .overrun                 (overrun),
    .step_count              (step_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int          cdr_e = BIG, cdr_f = BIG, isr_e = BIG, isr_f = BIG;
  int          div_m = 0;
  int          m_start = -1000;
  bit          m_ovr = 1'b0;
  logic [15:0] m_count = '0;
  logic [26:0] exp_vec;

  wire [26:0] obs_vec = {tick, snapshot_en, update_en, layer_sel, neuron_sel,
                         step_done, busy, overrun, step_count};

  task automatic set_cdr(input bit v);
    cdr_a = v;
    if (v) begin
      cdr_e = cyc;
      cdr_f = BIG;
      div_m = int'(div_value);
    end else begin
      cdr_f = cyc;
    end
  endtask

  task automatic set_isr(input bit v);
    isr_a = v;
    if (v) begin
      isr_e = cyc;
      isr_f = BIG;
    end else begin
      isr_f = cyc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cdr_a   = 1'b0;
    isr_a   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cdr_e = BIG; cdr_f = BIG; isr_e = BIG; isr_f = BIG;
    div_m = 0; m_start = -1000; m_ovr = 1'b0; m_count = '0;
  endtask

  // Advances to the next sample point and predicts this cycle's outputs.
  task automatic step_model();
    int c, o;
    bit t, isr_s, b, upd, lay;
    logic [3:0] ns;
    @(negedge clk);
    c = cyc;
    t = (c >= cdr_e + 3) && (c < cdr_f + 2) &&
        (((c - cdr_e - 3) % (div_m + 1)) == div_m);
    isr_s = (c >= isr_e + 2) && (c < isr_f + 2);
    o   = c - m_start;
    b   = (o >= 1) && (o <= DONE_OFF);
    upd = (o >= 2) && (o <= DONE_OFF - 1);
    lay = (o >= 2 + NH) && (o <= DONE_OFF - 1);
    ns  = !upd ? 4'd0 : (lay ? 4'(o - 2 - NH) : 4'(o - 2));
    if (o == DONE_OFF) m_count = m_count + 16'd1;
    exp_vec = {t, (o == 1), upd, lay, ns, (o == DONE_OFF), b, m_ovr, m_count};
    if (t) begin
      if (b) m_ovr = 1'b1;
      else if (isr_s) m_start = c;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step_model();
      n_total++;
      if (obs_vec !== exp_vec || obs_vec !== 27'd0)
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_tick_period();
    int e, first, prev;
    do_reset();
    div_value = 8'd20;
    step_model();
    set_cdr(1'b1);
    e = cyc; first = -1; prev = -1;
    for (int i = 0; i < 120; i++) begin
      step_model();
      n_total++;
      if (obs_vec !== exp_vec)
        $display("FAIL tick_period_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (tick) begin
        if (first < 0) first = cyc;
        if (prev >= 0) begin
          n_total++;
          if (cyc - prev !== 21) $display("FAIL tick_spacing got=%0d exp=21", cyc - prev);
          else n_pass++;
        end
        prev = cyc;
      end
    end
    n_total++;
    if (first < 0 || first - e !== 23)
      $display("FAIL first_tick_latency got=%0d exp=23", (first < 0) ? -1 : first - e);
    else n_pass++;
  endtask

  task automatic test_full_step();
    int t0, d;
    logic [5:0] e6;
    do_reset();
    div_value = 8'd20;
    set_isr(1'b1);
    set_cdr(1'b1);
    t0 = -1;
    for (int i = 0; i < 80; i++) begin
      step_model();
      n_total++;
      if (obs_vec !== exp_vec)
        $display("FAIL full_step_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (tick && t0 < 0) t0 = cyc;
      else if (t0 >= 0) begin
        d = cyc - t0;
        if (d == 1) begin
          n_total++;
          if (snapshot_en !== 1'b1) $display("FAIL snapshot_at_T1 got=%b exp=1", snapshot_en);
          else n_pass++;
        end
        if (d >= 2 && d <= 11) begin
          e6 = (d <= 9) ? {1'b1, 1'b0, 4'(d - 2)} : {1'b1, 1'b1, 4'(d - 10)};
          n_total++;
          if ({update_en, layer_sel, neuron_sel} !== e6)
            $display("FAIL update_seq d=%0d got=%b exp=%b", d, {update_en, layer_sel, neuron_sel}, e6);
          else n_pass++;
        end
        if (d == 12) begin
          n_total++;
          if ({step_done, step_count} !== {1'b1, 16'd1})
            $display("FAIL done_at_T12 got=%b/%0d exp=1/1", step_done, step_count);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (t0 < 0) $display("FAIL full_step_no_tick got=none exp=tick");
    else n_pass++;
  endtask

  task automatic test_overrun();
    int t0, d;
    do_reset();
    div_value = 8'd5;
    set_isr(1'b1);
    set_cdr(1'b1);
    t0 = -1;
    for (int i = 0; i < 90; i++) begin
      step_model();
      n_total++;
      if (obs_vec !== exp_vec)
        $display("FAIL overrun_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (tick && t0 < 0) t0 = cyc;
      else if (t0 >= 0) begin
        d = cyc - t0;
        if (d == 6 || d == 7) begin
          n_total++;
          if (overrun !== (d == 7)) $display("FAIL overrun_edge d=%0d got=%b exp=%b", d, overrun, d == 7);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_boundary();
    int t0, d;
    do_reset();
    div_value = 8'd12;
    set_isr(1'b1);
    set_cdr(1'b1);
    for (int i = 0; i < 110; i++) begin
      step_model();
      n_total++;
      if (obs_vec !== exp_vec)
        $display("FAIL boundary12_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
    end
    n_total++;
    if (overrun !== 1'b0 || step_count < 16'd5)
      $display("FAIL boundary12_end got=ovr%b/cnt%0d exp=ovr0/cnt>=5", overrun, step_count);
    else n_pass++;
    do_reset();
    div_value = 8'd11;
    set_isr(1'b1);
    set_cdr(1'b1);
    t0 = -1;
    for (int i = 0; i < 60; i++) begin
      step_model();
      n_total++;
      if (obs_vec !== exp_vec)
        $display("FAIL boundary11_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (tick && t0 < 0) t0 = cyc;
      else if (t0 >= 0) begin
        d = cyc - t0;
        if (d == 12 || d == 13) begin
          n_total++;
          if (overrun !== (d == 13)) $display("FAIL boundary11_ovr d=%0d got=%b exp=%b", d, overrun, d == 13);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_step();
    int t0;
    do_reset();
    div_value = 8'd20;
    set_isr(1'b1);
    set_cdr(1'b1);
    t0 = -1;
    for (int i = 0; i < 60; i++) begin
      step_model();
      n_total++;
      if (obs_vec !== exp_vec)
        $display("FAIL midreset_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (tick && t0 < 0) t0 = cyc;
      if (t0 >= 0 && cyc == t0 + 5) break;
    end
    n_total++;
    if (t0 < 0) begin
      $display("FAIL midreset_no_tick got=none exp=tick");
    end else begin
      reset_n = 1'b0;
      @(negedge clk);
      if ({busy, update_en, snapshot_en, step_done, layer_sel, neuron_sel, step_count} !== 25'd0)
        $display("FAIL midreset_abort got=busy%b upd%b done%b cnt%0d exp=0", busy, update_en, step_done, step_count);
      else n_pass++;
    end
  endtask

  task automatic test_late_div();
    int prev;
    do_reset();
    div_value = 8'd14;
    set_isr(1'b1);
    set_cdr(1'b1);
    prev = -1;
    for (int i = 0; i < 130; i++) begin
      step_model();
      if (i == 30) div_value = 8'd3;
      if (i == 80) set_cdr(1'b0);
      if (i == 86) set_cdr(1'b1);
      n_total++;
      if (obs_vec !== exp_vec)
        $display("FAIL late_div_vec cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      else n_pass++;
      if (tick && i < 80) begin
        if (prev >= 0) begin
          n_total++;
          if (cyc - prev !== 15) $display("FAIL late_div_period got=%0d exp=15", cyc - prev);
          else n_pass++;
        end
        prev = cyc;
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      do_reset();
      div_value = DIV_W'($urandom_range(0, 25));
      set_isr(1'b1);
      set_cdr(1'b1);
      for (int i = 0; i < 200; i++) begin
        step_model();
        n_total++;
        if (obs_vec !== exp_vec)
          $display("FAIL random_vec r=%0d cyc=%0d got=%h exp=%h", r, cyc, obs_vec, exp_vec);
        else n_pass++;
        if ($urandom_range(0, 39) == 0) set_isr(!isr_a);
        if ($urandom_range(0, 79) == 0) set_cdr(!cdr_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_full_step();
    test_overrun();
    test_boundary();
    test_reset_mid_step();
    test_late_div();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
